// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Sequences fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control_fsm #(
  parameter bit MEM_WAIT = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rdy;
  logic             pc_update;
  logic             branch;
  logic             retire;

  // Without memory waits every access is treated as completing immediately.
  assign rdy = (MEM_WAIT == 1'b0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = rdy;
        pc_update  = rdy;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target (OldPC + imm) is parked in ALUOut here.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign pc_write  = pc_update | (branch & zero);
  assign state_o   = state_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: a per-instruction phase-list model predicts state and controls each cycle.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  // DUT A: MEM_WAIT=1, CNT_W=32
  logic a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
  logic [1:0] a_rs, a_sa, a_sb, a_aop, a_imm;
  logic [3:0] a_st;
  logic [31:0] a_cnt;
  // DUT B: MEM_WAIT=0, CNT_W=4
  logic b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
  logic [1:0] b_rs, b_sa, b_sb, b_aop, b_imm;
  logic [3:0] b_st;
  logic [3:0] b_cnt;

  multicycle_control_fsm #(.MEM_WAIT(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pcw), .adr_src(a_adr), .mem_write(a_mw), .ir_write(a_irw),
    .reg_write(a_rw), .result_src(a_rs), .alu_src_a(a_sa), .alu_src_b(a_sb),
    .alu_op(a_aop), .imm_src(a_imm), .illegal_op(a_ill), .state_o(a_st),
    .instret(a_cnt));

  multicycle_control_fsm #(.MEM_WAIT(1'b0), .CNT_W(4)) dut_nw (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(b_pcw), .adr_src(b_adr), .mem_write(b_mw), .ir_write(b_irw),
    .reg_write(b_rw), .result_src(b_rs), .alu_src_a(b_sa), .alu_src_b(b_sb),
    .alu_op(b_aop), .imm_src(b_imm), .illegal_op(b_ill), .state_o(b_st),
    .instret(b_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  bit sel = 1'b0;

  logic [13:0] obs_vec;
  logic [1:0]  obs_imm;
  logic [3:0]  obs_st;
  logic [31:0] obs_cnt;

  always_comb begin
    if (sel) begin
      obs_vec = {b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_aop, b_ill};
      obs_imm = b_imm;
      obs_st  = b_st;
      obs_cnt = {28'd0, b_cnt};
    end else begin
      obs_vec = {a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_aop, a_ill};
      obs_imm = a_imm;
      obs_st  = a_st;
      obs_cnt = a_cnt;
    end
  end

  function automatic bit legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal_op}
  function automatic logic [13:0] exp_out(input int p, input logic r, input logic z, input logic [6:0] o);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, aop;
    {pcw, adr, mw, irw, rw, ill} = 6'b0;
    {rs, sa, sb, aop} = 8'b0;
    case (p)
      0:  begin irw = r; pcw = r; sb = 2'b10; rs = 2'b10; end
      1:  begin sa = 2'b01; sb = 2'b01; ill = !legal(o); end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  rw = 1'b1;
      8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      10: begin sa = 2'b10; aop = 2'b01; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, ill};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // Runs one instruction from FETCH; wf/wm are not-ready cycles in FETCH and in the memory phase.
  task automatic run_instr(input logic [6:0] o, input logic z, input int wf, input int wm);
    int ph[$];
    ph = '{0, 1};
    if (o == LW)      ph = '{0, 1, 2, 3, 4};
    else if (o == SW) ph = '{0, 1, 2, 5};
    else if (o == RT) ph = '{0, 1, 6, 7};
    else if (o == IT) ph = '{0, 1, 8, 7};
    else if (o == JL) ph = '{0, 1, 9, 7};
    else if (o == BQ) ph = '{0, 1, 10};
    foreach (ph[i]) begin
      int w;
      w = 0;
      if (!sel && ph[i] == 0) w = wf;
      if (!sel && (ph[i] == 3 || ph[i] == 5)) w = wm;
      for (int k = 0; k <= w; k++) begin
        logic r;
        op = o;
        zero = z;
        mem_ready = sel ? 1'($urandom_range(0, 1)) : (k == w);
        r = sel ? 1'b1 : mem_ready;
        @(negedge clk);
        checks++;
        if (obs_st !== 4'(ph[i])) begin
          failures++;
          $display("FAIL state op=%b phase=%0d: got %0d expected %0d", o, i, obs_st, ph[i]);
        end
        checks++;
        if (obs_vec !== exp_out(ph[i], r, z, o)) begin
          failures++;
          $display("FAIL controls op=%b state=%0d: got %b expected %b", o, ph[i], obs_vec, exp_out(ph[i], r, z, o));
        end
        checks++;
        if (obs_imm !== exp_imm(o)) begin
          failures++;
          $display("FAIL imm_src op=%b: got %b expected %b", o, obs_imm, exp_imm(o));
        end
        @(posedge clk); #1;
      end
    end
    if (legal(o)) begin
      if (sel) cnt_b = (cnt_b + 1) % 16;
      else cnt_a++;
    end
    checks++;
    if (obs_cnt !== 32'(sel ? cnt_b : cnt_a)) begin
      failures++;
      $display("FAIL instret op=%b: got %0d expected %0d", o, obs_cnt, sel ? cnt_b : cnt_a);
    end
    checks++;
    if (obs_st !== 4'd0) begin
      failures++;
      $display("FAIL back_to_fetch op=%b: got %0d expected 0", o, obs_st);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if ({a_st, a_mw, a_rw, a_cnt} !== 38'd0) begin
      failures++;
      $display("FAIL reset_idle: got st=%0d mw=%b rw=%b cnt=%0d expected all 0", a_st, a_mw, a_rw, a_cnt);
    end
    @(posedge clk); #1;
    run_instr(RT, 1'b0, 0, 0);
    op = SW;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (a_st !== 4'd5 || a_mw !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_memwrite: got st=%0d mw=%b expected 5 1", a_st, a_mw);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_st !== 4'd0 || a_mw !== 1'b0 || a_cnt !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: got st=%0d mw=%b cnt=%0d expected 0 0 0", a_st, a_mw, a_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic test_lw_waits();
    sel = 1'b0;
    do_reset();
    run_instr(LW, 1'b0, 2, 1);
  endtask

  task automatic test_beq();
    sel = 1'b0;
    do_reset();
    run_instr(BQ, 1'b1, 0, 0);
    run_instr(BQ, 1'b0, 0, 0);
  endtask

  task automatic test_jal();
    sel = 1'b0;
    do_reset();
    run_instr(JL, 1'b0, 1, 0);
  endtask

  task automatic test_illegal();
    sel = 1'b0;
    do_reset();
    run_instr(SW, 1'b0, 0, 2);
    run_instr(7'b1111111, 1'b0, 0, 0);
  endtask

  task automatic test_wrap_nowait();
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(RT, 1'b0, 0, 0);
    checks++;
    if (b_cnt !== 4'd0) begin
      failures++;
      $display("FAIL instret_wrap: got %0d expected 0", b_cnt);
    end
    run_instr(LW, 1'b0, 0, 0);
    run_instr(SW, 1'b1, 0, 0);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [7];
    ops = '{LW, SW, RT, IT, JL, BQ, 7'b0000000};
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 6) == 0) o = 7'($urandom);
      run_instr(o, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_lw_waits();
    test_beq();
    test_jal();
    test_illegal();
    test_wrap_nowait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
